// File: rtl/instruction_fetcher_if.sv
// Bus bundle between the instruction fetcher, its memory_controller port
// and the decode stage. The master side is the fetcher; the slave side is
// the surrounding environment (controller plus decoder).
interface instruction_fetcher_if;
    // memory_controller request side
    logic       mem_en;
    logic       mem_burst_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_di;
    logic       mem_we;
    logic       mem_do_ack;
    logic [7:0] mem_do;
    // redirect from the execute side
    logic       jump;
    logic [7:0] jump_addr;
    // decode-side valid/ready stream
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;

    modport master (
        output mem_en, mem_burst_en, mem_addr, mem_di, mem_we,
        output instr, instr_pc, instr_valid,
        input  mem_do_ack, mem_do, jump, jump_addr, instr_ready
    );

    modport slave (
        input  mem_en, mem_burst_en, mem_addr, mem_di, mem_we,
        input  instr, instr_pc, instr_valid,
        output mem_do_ack, mem_do, jump, jump_addr, instr_ready
    );
endinterface

// File: rtl/instruction_fetcher.sv
// Sequential instruction-byte fetcher. Requests bytes from memory_controller
// at fetch_pc, buffers acknowledged bytes with their address in a small FIFO
// and hands them to decode over valid/ready. A jump flushes the FIFO, moves
// fetch_pc to the target and spends one dead cycle (FLUSH) so that any ack
// still in flight for the old stream is thrown away.
module instruction_fetcher #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_fetcher_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] ZERO_PTR  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);
    localparam logic [CNT_W-1:0] ZERO_CNT  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    // Burst is only hinted while at least two slots remain, so a burst
    // beat arriving one cycle late still has room.
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(DEPTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [7:0]       fetch_pc_r;
    logic [7:0]       fetch_pc_next_s;
    logic [7:0]       fifo_pc_r   [DEPTH];
    logic [7:0]       fifo_byte_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    // Push/pop qualifiers; a jump suppresses both so the old stream dies.
    always_comb begin
        full_s = (count_r == FULL_CNT);
        pop_s  = (count_r != ZERO_CNT) && bus.instr_ready && !bus.jump;
        // Acks outside FETCH, or into a full FIFO with no pop, are dropped;
        // fetch_pc then stays put and the same address is requested again.
        push_s = bus.mem_do_ack && (state_r == ST_FETCH) && !bus.jump
                 && (!full_s || pop_s);
    end

    // Next values of fetch_pc, pointers and occupancy; jump clears the FIFO.
    always_comb begin
        rd_ptr_next_s   = rd_ptr_r;
        wr_ptr_next_s   = wr_ptr_r;
        count_next_s    = count_r;
        fetch_pc_next_s = fetch_pc_r;
        if (bus.jump) begin
            rd_ptr_next_s   = ZERO_PTR;
            wr_ptr_next_s   = ZERO_PTR;
            count_next_s    = ZERO_CNT;
            fetch_pc_next_s = bus.jump_addr;
        end else begin
            if (push_s) begin
                wr_ptr_next_s   = wr_ptr_r + ONE_PTR;
                fetch_pc_next_s = fetch_pc_r + 8'h01;
            end else begin
                wr_ptr_next_s   = wr_ptr_r;
                fetch_pc_next_s = fetch_pc_r;
            end
            if (pop_s) begin
                rd_ptr_next_s = rd_ptr_r + ONE_PTR;
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + ONE_CNT;
                2'b01:   count_next_s = count_r - ONE_CNT;
                default: count_next_s = count_r;
            endcase
        end
    end

    // Fetch FSM next-state: jump always lands in FLUSH, FETCH stalls on full.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.jump) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.jump) begin
                    state_next_s = ST_FLUSH;
                end else if (count_next_s == FULL_CNT) begin
                    state_next_s = ST_STALL;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_STALL: begin
                if (bus.jump) begin
                    state_next_s = ST_FLUSH;
                end else if (count_r < FULL_CNT) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_STALL;
                end
            end
            ST_FLUSH: begin
                if (bus.jump) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: request/burst from state and occupancy, head from rd_ptr.
    always_comb begin
        bus.mem_en       = (state_r == ST_FETCH);
        bus.mem_burst_en = (state_r == ST_FETCH) && (count_r <= BURST_MAX);
        bus.mem_addr     = fetch_pc_r;
        bus.mem_di       = 8'h00;
        bus.mem_we       = 1'b0;
        bus.instr_valid  = (count_r != ZERO_CNT);
        bus.instr        = fifo_byte_r[rd_ptr_r];
        bus.instr_pc     = fifo_pc_r[rd_ptr_r];
    end

    // Control registers: FSM state, fetch address, FIFO pointers and count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            rd_ptr_r   <= ZERO_PTR;
            wr_ptr_r   <= ZERO_PTR;
            count_r    <= ZERO_CNT;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            rd_ptr_r   <= rd_ptr_next_s;
            wr_ptr_r   <= wr_ptr_next_s;
            count_r    <= count_next_s;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero until filled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i]   <= 8'h00;
                fifo_byte_r[i] <= 8'h00;
            end
        end else if (push_s) begin
            fifo_pc_r[wr_ptr_r]   <= fetch_pc_r;
            fifo_byte_r[wr_ptr_r] <= bus.mem_do;
        end
    end

endmodule
